// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, done pulse after WIDTH+1 cycles.
// Define DIVISOR_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module divisor_secuencial #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             div_cero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic             zero_q;
`ifdef DIVISOR_SIGNED_EN
  logic             sign_a_q;
  logic             neg_q_q;
`endif

  // The remainder never reaches the divisor, so WIDTH bits hold it; the shifted
  // value needs WIDTH+1 bits before the trial subtraction.
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  assign r_sh = {r_q, q_q[WIDTH-1]};
  assign diff = r_sh - {1'b0, dvs_q};
  assign busy = (state_q == S_CALC);

  // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      zero_q   <= 1'b0;
      done     <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      div_cero <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
      sign_a_q <= 1'b0;
      neg_q_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            r_q      <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            zero_q   <= (divisor == '0);
            div_cero <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            sign_a_q <= dividendo[WIDTH-1];
            neg_q_q  <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
            q_q      <= dividendo[WIDTH-1] ? -dividendo : dividendo;
            dvs_q    <= divisor[WIDTH-1] ? -divisor : divisor;
`else
            q_q      <= dividendo;
            dvs_q    <= divisor;
`endif
          end
        end
        S_CALC: begin
          // A negative trial result restores the shifted remainder.
          r_q   <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          q_q   <= {q_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_DONE: begin
`ifdef DIVISOR_SIGNED_EN
          // On divide by zero q_q still holds |dividend|; the stored sign recovers it.
          if (zero_q) begin
            cociente <= '1;
            residuo  <= sign_a_q ? -q_q : q_q;
            div_cero <= 1'b1;
          end else begin
            cociente <= neg_q_q ? -q_q : q_q;
            residuo  <= sign_a_q ? -r_q : r_q;
          end
`else
          if (zero_q) begin
            cociente <= '1;
            residuo  <= q_q;
            div_cero <= 1'b1;
          end else begin
            cociente <= q_q;
            residuo  <= r_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: expected results queued at start, popped on done.
// Follows DIVISOR_SIGNED_EN to choose the signed or unsigned reference model.
module tb_divisor_secuencial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividendo;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] cociente;
  logic [31:0] residuo;
  logic        div_cero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  divisor_secuencial #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividendo(dividendo),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .cociente (cociente),
    .residuo  (residuo),
    .div_cero (div_cero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.z = (b == 32'd0);
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end
`ifdef DIVISOR_SIGNED_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  task automatic scoreboard_pop(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected_done: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (cociente !== e.q) begin
      failures++;
      $display("FAIL %s cociente: got %h expected %h (a=%h b=%h)", tag, cociente, e.q, e.a, e.b);
    end
    checks++;
    if (residuo !== e.r) begin
      failures++;
      $display("FAIL %s residuo: got %h expected %h (a=%h b=%h)", tag, residuo, e.r, e.a, e.b);
    end
    checks++;
    if (div_cero !== e.z) begin
      failures++;
      $display("FAIL %s div_cero: got %b expected %b (a=%h b=%h)", tag, div_cero, e.z, e.a, e.b);
    end
  endtask

  // One full transaction: issue start, wait for done, check result, latency, busy span, pulse width.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    int k;
    int bc;
    int exp_lat;
    int exp_busy;
    @(negedge clk);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    k  = 0;
    bc = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: done not seen within %0d cycles", tag, k);
      sb.delete();
      return;
    end
    scoreboard_pop(tag);
    exp_lat  = (b == 32'd0) ? 1 : 33;
    exp_busy = (b == 32'd0) ? 0 : 32;
    checks++;
    if (k != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", tag, k, exp_lat);
    end
    checks++;
    if (bc != exp_busy) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, bc, exp_busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: done got %b expected 0 one cycle later", tag, done);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    dividendo = 32'd100;
    divisor   = 32'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cociente !== 32'd0 || residuo !== 32'd0 || div_cero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b cociente=%h residuo=%h div_cero=%b expected all 0",
               busy, done, cociente, residuo, div_cero);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_start: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_div(32'd100, 32'd7, "basic_100_7");
    checks++;
    if (cociente !== 32'd14 || residuo !== 32'd2) begin
      failures++;
      $display("FAIL basic_const: got %0d r %0d expected 14 r 2", cociente, residuo);
    end
    run_div(32'hFFFF_FFFF, 32'd1, "max_div_1");
    run_div(32'd5, 32'd9, "small_div_big");
  endtask

  task automatic test_div_zero();
    run_div(32'd1234, 32'd0, "div_zero");
    run_div(32'd8, 32'd2, "after_div_zero");
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    dividendo = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    sb.push_back(model(32'd100, 32'd7));
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      if (k == 10) begin
        dividendo = 32'd50;
        divisor   = 32'd5;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ignore_timeout: done not seen within %0d cycles", k);
      sb.delete();
      return;
    end
    scoreboard_pop("ignore_start");
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
    checks++;
    if (k != 0) begin
      failures++;
      $display("FAIL ignore_dropped: got %0d extra done pulses expected 0", k);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    dividendo = 32'd123456;
    divisor   = 32'd789;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cociente !== 32'd0 || residuo !== 32'd0 || div_cero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b cociente=%h residuo=%h div_cero=%b expected all 0",
               busy, done, cociente, residuo, div_cero);
    end
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
    checks++;
    if (k != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", k);
    end
  endtask

  task automatic test_signed_cases();
    run_div(32'hFFFF_FFF9, 32'd2, "neg7_div_2");
    checks++;
`ifdef DIVISOR_SIGNED_EN
    if (cociente !== 32'hFFFF_FFFD || residuo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL neg7_const: got %h r %h expected fffffffd r ffffffff", cociente, residuo);
    end
`else
    if (cociente !== 32'h7FFF_FFFC || residuo !== 32'd1) begin
      failures++;
      $display("FAIL neg7_const: got %h r %h expected 7ffffffc r 00000001", cociente, residuo);
    end
`endif
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "min_div_neg1");
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, "neg_div_neg");
    run_div(32'hFFFF_FB2E, 32'd0, "neg_div_zero");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a;
    logic [31:0] b;
    @(negedge clk);
    a = 32'd1000;
    b = 32'd33;
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    sb.push_back(model(a, b));
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 60);
      if (done !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL b2b_timeout: done not seen within %0d cycles", n);
        sb.delete();
        start = 1'b0;
        return;
      end
      scoreboard_pop("back_to_back");
      checks++;
      if (n != 34) begin
        failures++;
        $display("FAIL b2b_period: got %0d cycles expected 34", n);
      end
      if (i < 2) begin
        a = $urandom;
        b = $urandom_range(1, 65535);
        dividendo = a;
        divisor   = b;
        sb.push_back(model(a, b));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 15);
      a   = (sel < 4) ? 32'($urandom_range(0, 1000)) : $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel < 8)  b = 32'($urandom_range(1, 255));
      else               b = $urandom;
      run_div(a, b, "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dividendo = 32'd0;
    divisor   = 32'd0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_signed_cases();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
